// File: rtl/del_prog.sv
// del_prog: multi-channel programmable delay unit for 2-phase (toggle) requests.
//
// Each channel watches its in_r bit. Every level change is one event. The unit
// reproduces that event on out_r after max(del_cfg,1) clock cycles, with a
// one-cycle fire pulse at the same moment. Events that arrive while a channel
// is counting are queued in a small saturating pending counter. They are then
// replayed back-to-back, spaced one full delay apart. An event that arrives
// when the queue is already full is dropped and sets a sticky ovf bit.
//
// Ports:
//   clk      in   1    clock, rising edge
//   rst_n    in   1    synchronous active-low reset
//   en       in   1    global enable; 0 freezes counters/pending service, capture continues
//   del_cfg  in   DW   delay in cycles, sampled at each counter load (0 behaves as 1)
//   in_r     in   NCH  2-phase request per channel
//   out_r    out  NCH  2-phase delayed request
//   fire     out  NCH  one-cycle pulse coincident with each out_r toggle
//   busy     out  NCH  channel is counting a delay
//   ovf      out  NCH  sticky: an event was dropped because pending was full
//   ovf_clr  in   1    synchronous clear of all ovf bits (a same-cycle set wins)
module del_prog #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int PW  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [DW-1:0]  del_cfg,
  input  logic [NCH-1:0] in_r,
  output logic [NCH-1:0] out_r,
  output logic [NCH-1:0] fire,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] ovf,
  input  logic           ovf_clr
);

  localparam logic [PW-1:0] PEND_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [DW-1:0]  cnt_q   [NCH];
  logic [DW-1:0]  cnt_d   [NCH];
  logic [PW-1:0]  pend_q  [NCH];
  logic [PW-1:0]  pend_d  [NCH];
  logic [NCH-1:0] in_q;
  logic [NCH-1:0] out_q, out_d;
  logic [NCH-1:0] fire_q, fire_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] drop;
  logic [NCH-1:0] ev;
  logic [DW-1:0]  load_val;

  assign ev       = in_r ^ in_q;
  assign load_val = (del_cfg == '0) ? DW'(1) : del_cfg;

  // Next-state logic for all channels. Channels share only del_cfg and en.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pend_d[i]  = pend_q[i];
      out_d[i]   = out_q[i];
      fire_d[i]  = 1'b0;
      drop[i]    = 1'b0;

      if (en) begin
        if (state_q[i] == IDLE || cnt_q[i] == DW'(1)) begin
          // Load opportunity: either idle, or the terminal count of a run.
          if (state_q[i] == RUN) begin
            out_d[i]  = ~out_q[i];
            fire_d[i] = 1'b1;
          end
          if (ev[i]) begin
            // A same-cycle event is consumed directly. Pending is left untouched.
            cnt_d[i]   = load_val;
            state_d[i] = RUN;
          end else if (pend_q[i] != '0) begin
            cnt_d[i]   = load_val;
            pend_d[i]  = pend_q[i] - PW'(1);
            state_d[i] = RUN;
          end else begin
            state_d[i] = IDLE;
          end
        end else begin
          cnt_d[i] = cnt_q[i] - DW'(1);
          if (ev[i]) begin
            if (pend_q[i] == PEND_MAX) drop[i] = 1'b1;
            else                       pend_d[i] = pend_q[i] + PW'(1);
          end
        end
      end else if (ev[i]) begin
        // Frozen: counting stops, but events are still queued.
        if (pend_q[i] == PEND_MAX) drop[i] = 1'b1;
        else                       pend_d[i] = pend_q[i] + PW'(1);
      end
    end
    ovf_d = (ovf_q & ~{NCH{ovf_clr}}) | drop;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then sees the values from before the edge, whatever order the statements run in.
    if (!rst_n) begin
      // NOTE: the per-channel arrays are a few flops each, not RAM, so they are
      // reset with everything else. A reset then discards every queued event.
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
      in_q   <= in_r;   // absorb the current level so release creates no event
      out_q  <= '0;
      fire_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pend_q[i]  <= pend_d[i];
      end
      in_q   <= in_r;
      out_q  <= out_d;
      fire_q <= fire_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) busy[i] = (state_q[i] == RUN);
  end

  assign out_r = out_q;
  assign fire  = fire_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/del_prog.md
Name: del_prog

Overview:
- Multi-channel programmable delay unit; clocked, parametrised successor to the single fixed delay element used between pipeline stages.
- Each channel takes a 2-phase request (toggle) and reproduces it on out_r after a programmable number of clock cycles, with a one-cycle fire pulse.
- Requests that arrive while a channel is busy are counted and replayed back-to-back; queue overflow is flagged.
- Sits between handshake stages wherever a matched or tunable request delay is required.

Parameters:
- NCH, 4, number of independent channels.
- DW, 8, width of the delay configuration value.
- PW, 3, width of the per-channel pending counter; PEND_MAX = 2^PW - 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  global enable; 0 freezes all counters and the pending logic, but event capture continues.
- del_cfg  in  DW  delay in cycles; sampled at each counter load; 0 is treated as 1.
- in_r  in  NCH  2-phase request per channel; every level change is one event.
- out_r  out  NCH  2-phase delayed request; toggles once per serviced event.
- fire  out  NCH  one-cycle pulse, coincident with each out_r toggle.
- busy  out  NCH  channel is counting a delay.
- ovf  out  NCH  sticky flag: an event was dropped because pending was full.
- ovf_clr  in  1  synchronous clear of all ovf bits.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_r=0, fire=0, busy=0, ovf=0, counters=0, pending=0.
  - The in_r history register loads in_r, so no spurious event occurs after reset.
- Event detect: ev[i] = in_r[i] XOR in_r_q[i]. in_r_q is updated every cycle, even when en=0.
- Events seen while en=0 are recorded into pending, subject to saturation.
- Per-channel FSM, all updates gated by en:
  - IDLE, ev, en=1: load cnt = max(del_cfg,1); go to RUN; busy=1 from the next cycle.
  - RUN, cnt>1: cnt decrements by 1.
  - RUN, cnt==1 (terminal): out_r toggles and fire=1 for that cycle.
    - If pending>0, or ev is present this cycle: reload cnt from del_cfg, stay in RUN. pending is decremented, unless a same-cycle ev is consumed directly.
    - Otherwise go to IDLE; busy=0.
  - IDLE with pending>0 (only reachable when en was low at the event): on en=1, load and decrement pending.
- Latency: an event sampled at edge t with D = max(del_cfg,1) and the channel idle gives an out_r toggle and fire pulse after edge t+D.
  - Back-to-back queued events are spaced exactly D cycles apart.
- Pending rules:
  - An ev while in RUN and not terminal increments pending.
  - At saturation (pending == PEND_MAX) the event is dropped and ovf[i] is set.
  - Simultaneous ev and terminal: the event becomes the reload; pending is unchanged.
- ovf_clr together with a new overflow in the same cycle: the set wins; ovf stays 1.
- del_cfg changes mid-count do not affect the running count; they apply at the next load.
- Reset mid-operation discards all counts and pending events; out_r returns to 0.
- Channels are fully independent; the same cycle on different channels never interacts.
- fire is never high for more than one consecutive cycle per serviced event. Back-to-back events with D=1 give fire high on consecutive cycles, and out_r toggles every cycle.

Test Plan:
- Reset then idle: in_r held at 4'b1010 through reset release -> no fire, out_r=0 for 20 cycles.
- Single event: del_cfg=5, toggle in_r[0] at edge t -> out_r[0]=1 and fire[0]=1 after edge t+5 only; busy[0] high for cycles t+1..t+5.
- Zero delay: del_cfg=0, toggle in_r[2] -> out_r[2] toggles after edge t+1 (treated as D=1).
- Queueing: del_cfg=4, four toggles of in_r[1] on cycles t..t+3 -> fire[1] at t+4, t+8, t+12, t+16; out_r[1] ends at 0; ovf[1]=0.
- Overflow: PW=3, del_cfg=20, 10 toggles while busy -> 7 events queued, later ones dropped, ovf[1]=1. Exactly 8 fires total. ovf_clr -> ovf[1]=0.
- en freeze and reset: del_cfg=6, event, en=0 for 3 cycles mid-count -> fire delayed by 3 cycles. Repeat with rst_n=0 mid-count -> no fire; out_r=0, busy=0.
